somador_serial: RTL

Bit-serial adder that computes an N-bit sum with a single 1-bit full-adder slice, processing one bit per clock, LSB first. It is the sequencing stage around the team's 1-bit full-adder cell. The block latches two operands and a carry-in, feeds the slice one bit pair per cycle, and keeps the slice's carry-out in a flip-flop as the next cycle's carry-in. It then presents the assembled WIDTH-bit sum and final carry with a one-cycle done pulse.

---
 rtl/somador_serial.sv | 117 +++++++++++
 1 files changed

// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder built around a single 1-bit full-adder slice.
// It processes one bit pair per clock, LSB first, and keeps the slice's carry-out
// in a flip-flop so it becomes the next cycle's carry-in. When the last bit is
// done it presents the full WIDTH-bit sum and the final carry together with a
// one-cycle done pulse.
module somador_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [WIDTH-1:0] sSh_q, sSh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;

   logic             sumBit;
   logic             carryNext;
   logic [WIDTH-1:0] sShNext;

   // Full-adder slice on the current LSB pair, and the sum register after this bit
   always_comb begin
      sumBit    = aSh_q[0] ^ bSh_q[0] ^ carry_q;
      carryNext = (aSh_q[0] & bSh_q[0]) | (carry_q & (aSh_q[0] ^ bSh_q[0]));
      sShNext   = {sumBit, sSh_q[WIDTH-1:1]};
   end

   // Sequencing: capture on start, shift one bit per cycle, publish the result at the last bit
   always_comb begin
      state_d = state_q;
      aSh_d   = aSh_q;
      bSh_d   = bSh_q;
      sSh_d   = sSh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               aSh_d   = a;
               bSh_d   = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = carryNext;
            aSh_d   = {1'b0, aSh_q[WIDTH-1:1]};
            bSh_d   = {1'b0, bSh_q[WIDTH-1:1]};
            sSh_d   = sShNext;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               s_d     = sShNext;
               cout_d  = carryNext;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aSh_q   <= '0;
         bSh_q   <= '0;
         sSh_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         aSh_q   <= aSh_d;
         bSh_q   <= bSh_d;
         sSh_q   <= sSh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;

endmodule
